bin_to_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per cycle.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_add3_digit.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 116 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // 10^n as a 64-bit constant; wide enough for the largest digit count.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_nib,
  output logic [BCD_W-1:0] o_nib
);

  always_comb begin
    o_nib = i_nib;
    if (i_nib >= BCD_W'(5)) begin
      o_nib = i_nib + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) with
// saturating overflow and a leading-zero mask for display blanking.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BCD_W*DIGITS-1:0] o_bcd,
  output logic                    o_ovf,
  output logic [DIGITS-1:0]       o_lead_mask
);

  localparam int unsigned WORK_W = BCD_W * DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W);

  localparam logic [63:0]       MAX_VAL  = pow10(DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(BIN_W - 1);
  localparam logic [DIGITS-1:0] MASK_RST = {DIGITS{1'b1}} << 1;

  state_t              state_q;
  logic [BIN_W-1:0]    shift_q;
  logic [WORK_W-1:0]   work_q;
  logic [WORK_W-1:0]   work_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_pend_q;
  logic                busy_q;
  logic                done_q;
  logic [WORK_W-1:0]   bcd_q;
  logic                ovf_q;
  logic [DIGITS-1:0]   mask_q;
  logic [DIGITS-1:0]   mask_nxt;
  logic                zero_above;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_nib (work_q[k*BCD_W +: BCD_W]),
      .o_nib (work_adj[k*BCD_W +: BCD_W])
    );
  end

  // Digit k is blank only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    zero_above = 1'b1;
    mask_nxt   = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (work_q[k*BCD_W +: BCD_W] == '0);
      mask_nxt[k] = zero_above;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      mask_q     <= MASK_RST;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            shift_q    <= i_bin;
            work_q     <= '0;
            cnt_q      <= CNT_INIT;
            ovf_pend_q <= 64'(i_bin) > MAX_VAL;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Bits leaving the top digit are dropped; overflow is flagged separately.
          work_q  <= {work_adj[WORK_W-2:0], shift_q[BIN_W-1]};
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          ovf_q  <= ovf_pend_q;
          if (ovf_pend_q) begin
            bcd_q  <= {DIGITS{4'h9}};
            mask_q <= '0;
          end else begin
            bcd_q  <= work_q;
            mask_q <= mask_nxt;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_bcd       = bcd_q;
  assign o_ovf       = ovf_q;
  assign o_lead_mask = mask_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (BIN_W=20, DIGITS=6) against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W  = 20;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned LAT    = BIN_W + 1;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [19:0] i_bin = '0;
  logic        o_busy;
  logic        o_done;
  logic [23:0] o_bcd;
  logic        o_ovf;
  logic [5:0]  o_lead_mask;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_bin       (i_bin),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_bcd       (o_bcd),
    .o_ovf       (o_ovf),
    .o_lead_mask (o_lead_mask)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: plain decimal arithmetic.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    if (v > 999999) return 24'h999999;
    r = '0;
    t = v;
    for (int k = 0; k < 6; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_mask(input int unsigned v);
    logic [5:0] m;
    int unsigned p;
    if (v > 999999) return 6'b000000;
    m = '0;
    p = 10;
    for (int k = 1; k < 6; k++) begin
      m[k] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  function automatic int unsigned rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 1048575);
      1:       return $urandom_range(0, 99);
      2:       return $urandom_range(0, 9999);
      default: return $urandom_range(999990, 1048575);
    endcase
  endfunction

  // Starts one conversion from idle; returns edges from accept to the o_done sample.
  task automatic run_conv(input int unsigned v, output int lat, output bit timeout);
    @(negedge i_clk);
    i_start = 1'b1;
    i_bin   = 20'(v);
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    i_bin   = 20'($urandom);
    lat     = 0;
    timeout = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        lat     = i;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++;
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++;
    if (o_bcd !== 24'h000000) begin errors++; $display("FAIL reset_bcd got %h want 000000", o_bcd); end
    checks++;
    if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
    checks++;
    if (o_lead_mask !== 6'b111110) begin
      errors++; $display("FAIL reset_mask got %b want 111110", o_lead_mask);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic test_known();
    int unsigned vals [8] = '{0, 123456, 42, 999999, 1000000, 1048575, 7, 100000};
    int lat;
    bit to;
    logic [23:0] held;
    foreach (vals[i]) begin
      run_conv(vals[i], lat, to);
      checks++;
      if (to || lat != LAT) begin
        errors++; $display("FAIL known_latency v=%0d got %0d want %0d", vals[i], lat, LAT);
      end
      checks++;
      if (o_bcd !== ref_bcd(vals[i])) begin
        errors++; $display("FAIL known_bcd v=%0d got %h want %h", vals[i], o_bcd, ref_bcd(vals[i]));
      end
      checks++;
      if (o_ovf !== (vals[i] > 999999)) begin
        errors++; $display("FAIL known_ovf v=%0d got %b", vals[i], o_ovf);
      end
      checks++;
      if (o_lead_mask !== ref_mask(vals[i])) begin
        errors++;
        $display("FAIL known_mask v=%0d got %b want %b", vals[i], o_lead_mask, ref_mask(vals[i]));
      end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL known_busy_at_done got %b want 0", o_busy); end
      held = ref_bcd(vals[i]);
      @(posedge i_clk);
      #1;
      checks++;
      if (o_done !== 1'b0 || o_bcd !== held) begin
        errors++; $display("FAIL known_hold done=%b bcd=%h want done=0 bcd=%h", o_done, o_bcd, held);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_bin   = 20'd500;
    @(negedge i_clk);
    i_start = 1'b0;
    i_bin   = 20'd3;
    repeat (5) @(negedge i_clk);
    i_start = 1'b1;
    i_bin   = 20'd7;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) ndone++;
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL busy_ignore_dones got %0d want 1", ndone); end
    checks++;
    if (o_bcd !== 24'h000500) begin errors++; $display("FAIL busy_ignore_bcd got %h want 000500", o_bcd); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle got %b want 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int lat;
    bit to;
    @(negedge i_clk);
    i_start = 1'b1;
    i_bin   = 20'd777;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (7) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_bcd !== 24'h0 || o_ovf !== 1'b0 ||
        o_lead_mask !== 6'b111110) begin
      errors++;
      $display("FAIL reset_mid_outputs busy=%b done=%b bcd=%h ovf=%b mask=%b want 0 0 000000 0 111110",
               o_busy, o_done, o_bcd, o_ovf, o_lead_mask);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL reset_mid_no_done got %0d want 0", ndone); end
    run_conv(10, lat, to);
    checks++;
    if (to || o_bcd !== 24'h000010 || o_lead_mask !== 6'b111100) begin
      errors++;
      $display("FAIL reset_mid_restart to=%b bcd=%h mask=%b want 000010 111100", to, o_bcd, o_lead_mask);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned v;
    int unsigned pend;
    bit cap = 1'b0;
    int ndone = 0;
    int edge_n = 0;
    int last = 0;
    @(negedge i_clk);
    v       = rand_val();
    i_start = 1'b1;
    i_bin   = 20'(v);
    pend    = v;
    for (int c = 0; c < 400 && ndone < 12; c++) begin
      @(posedge i_clk);
      #1;
      edge_n++;
      if (o_done) begin
        checks++;
        if (o_bcd !== ref_bcd(pend) || o_ovf !== (pend > 999999) || o_lead_mask !== ref_mask(pend)) begin
          errors++;
          $display("FAIL b2b_result v=%0d got %h/%b/%b want %h/%b/%b", pend, o_bcd, o_ovf,
                   o_lead_mask, ref_bcd(pend), (pend > 999999), ref_mask(pend));
        end
        checks++;
        if (edge_n - last != BIN_W + 2) begin
          errors++; $display("FAIL b2b_spacing got %0d want %0d", edge_n - last, BIN_W + 2);
        end
        last = edge_n;
        ndone++;
        cap = 1'b1;
      end
      @(negedge i_clk);
      v     = rand_val();
      i_bin = 20'(v);
      if (cap) begin
        pend = v;
        cap  = 1'b0;
      end
    end
    checks++;
    if (ndone < 12) begin errors++; $display("FAIL b2b_timeout got %0d dones want 12", ndone); end
    i_start = 1'b0;
    repeat (30) @(posedge i_clk);
  endtask

  initial begin
    test_reset();
    test_known();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
